// File: rtl/work_tx_pkg.sv
// rtl/work_tx_pkg.sv - shared job-link constants, framer state type and baud divider
package work_tx_pkg;

  localparam int JOB_BYTES  = 96;
  localparam int MIDSTATE_W = 512;
  localparam int DATA2_W    = 256;
  localparam int JOB_W      = MIDSTATE_W + DATA2_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_GAP
  } tx_state_e;

  // Clocks per bit, truncating; the receiver derives its sampling from the same value.
  function automatic int baud_div(input int clock, input int baud);
    return clock / baud;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte framer with optional inter-byte gap and tvalid/tready intake
// A byte offered in the last cycle of a frame starts its start bit on the very next cycle.
module uart_tx_byte
  import work_tx_pkg::*;
#(
  parameter int DIV      = 217,
  parameter int GAP_BITS = 0
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] tdata_i,
  input  logic       tvalid_i,
  output logic       tready_o,
  output logic       end_next_o,
  output logic       tx_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BAUD_PEN  = CW'(DIV - 2);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          tick, last_period, frame_end;

  assign tick        = (baud_q == BAUD_LAST);
  assign last_period = ((state_q == ST_STOP) && (GAP_BITS == 0)) ||
                       ((state_q == ST_GAP) && (gap_q == GAP_LAST));
  assign frame_end   = last_period && tick;
  assign tready_o    = (state_q == ST_IDLE) || frame_end;
  // One cycle of warning before the frame's final cycle; needs DIV >= 2.
  assign end_next_o  = last_period && (baud_q == BAUD_PEN);
  assign tx_o        = tx_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if (state_q != ST_IDLE) begin
      baud_d = tick ? '0 : baud_q + 1'b1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (tvalid_i) begin
          state_d = ST_START;
          shift_d = tdata_i;
          tx_d    = 1'b0;
          baud_d  = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        if (tick && (GAP_BITS > 0)) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end
      end
      ST_GAP: begin
        if (tick) begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (frame_end) begin
      if (tvalid_i) begin
        state_d = ST_START;
        shift_d = tdata_i;
        tx_d    = 1'b0;
      end else begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/work_tx.sv
// rtl/work_tx.sv - serializes one 768-bit job as 96 UART bytes, data2 LSB byte first
module work_tx
  import work_tx_pkg::*;
#(
  parameter int CLOCK    = 25000000,
  parameter int BAUD     = 115200,
  parameter int GAP_BITS = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [MIDSTATE_W-1:0] midstate,
  input  logic [DATA2_W-1:0]    data2,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int         DIV       = baud_div(CLOCK, BAUD);
  localparam logic [6:0] LAST_BYTE = 7'(JOB_BYTES - 1);

  logic [JOB_W-1:0] shreg_q, shreg_d;
  logic [6:0]       byte_cnt_q, byte_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept, byte_tvalid, byte_tready, byte_end_next;
  logic [7:0]       byte_tdata;

  assign accept      = start && !busy_q;
  assign byte_tvalid = accept || (busy_q && (byte_cnt_q != LAST_BYTE));
  // Byte 0 goes straight into the framer on accept; the shift register holds the rest.
  assign byte_tdata  = busy_q ? shreg_q[7:0] : data2[7:0];

  always_comb begin
    shreg_d    = shreg_q;
    byte_cnt_d = byte_cnt_q;
    busy_d     = busy_q;
    done_d     = busy_q && (byte_cnt_q == LAST_BYTE) && byte_end_next;
    if (accept) begin
      shreg_d    = {midstate, data2} >> 8;
      byte_cnt_d = '0;
      busy_d     = 1'b1;
    end else if (busy_q && byte_tvalid && byte_tready) begin
      shreg_d    = shreg_q >> 8;
      byte_cnt_d = byte_cnt_q + 1'b1;
    end
    if (done_q) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q    <= '0;
      byte_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  uart_tx_byte #(
    .DIV      (DIV),
    .GAP_BITS (GAP_BITS)
  ) u_uart_tx_byte (
    .clk_i      (clk),
    .reset_i    (reset),
    .tdata_i    (byte_tdata),
    .tvalid_i   (byte_tvalid),
    .tready_o   (byte_tready),
    .end_next_o (byte_end_next),
    .tx_o       (tx)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/work_tx.md
# work_tx

Serial work-packet transmitter, the initiator end of the job link that `serial_core` receives on. It takes one 768-bit job (512-bit midstate plus 256-bit data2), serializes it as 96 UART bytes (8N1) on a single TX line, and signals completion. It sits in the controller or chaining FPGA, or in a loopback bench, and drives the `RxD` pin of a hashing FPGA.

## Interface
- `CLOCK`, default 25000000: clock rate in Hz.
- `BAUD`, default 115200: line rate in bits per second.
- `GAP_BITS`, default 0: idle bit-times inserted after each stop bit (inter-byte gap).
- `clk` in, 1 bit: sole clock, the comm clock domain.
- `reset` in, 1 bit: synchronous, active-high.
- `start` in, 1 bit: single-cycle job request; sampled only while `busy`=0.
- `midstate` in, 512 bits: job midstate; captured on an accepted `start`.
- `data2` in, 256 bits: job data; captured on an accepted `start`.
- `tx` out, 1 bit: UART line, idle high.
- `busy` out, 1 bit: high from the cycle after an accepted `start` until the packet completes.
- `done` out, 1 bit: single-cycle pulse when the last stop bit (plus its gap) ends.

## Operation
- `DIV` = `CLOCK`/`BAUD`, integer division with truncation (217 at the defaults). Each bit lasts exactly `DIV` clocks.
- Capture: an accepted `start` latches {`midstate`,`data2`} into a 768-bit shift register. Later input changes have no effect.
- Byte order: byte 0 = data2[7:0], byte 1 = data2[15:8], …, byte 31 = data2[255:248], byte 32 = midstate[7:0], …, byte 95 = midstate[511:504]. The shift register shifts right 8 bits per byte.
- Frame per byte: one start bit (0), 8 data bits LSB-first, one stop bit (1), then `GAP_BITS` idle bits (1).
- FSM states:
  - IDLE: `tx`=1, `busy`=0. `start` moves to START.
  - START: send bit 0 for `DIV` clocks, then go to DATA.
  - DATA: send 8 bits, then go to STOP.
  - STOP: send 1 for `DIV` clocks. If `GAP_BITS`>0, go to GAP. Otherwise, if the byte counter is below 95, go to START with the counter incremented; at 95, go to IDLE and pulse `done`.
  - GAP: send 1 for `GAP_BITS`×`DIV` clocks, then take the same counter branch as STOP.
- Counters:
  - Baud counter: 0..`DIV`-1.
  - Bit index: 0..7.
  - Byte counter: 7-bit, 0..95, never wraps past 95.
- `start` while `busy`=1 is ignored: no queueing, no restart.
- `start` in the same cycle as the `done` pulse is ignored. A new job needs `start` on or after the first cycle with `busy`=0.
- Reset mid-packet: the frame is abandoned, `tx` returns to 1 on the next cycle, and no `done` is produced. The truncated byte is acceptable, because the receiver's idle detection resynchronizes.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, FSM=IDLE, all counters=0.
- `start` accepted at cycle T: `busy`=1 and `tx`=0 (start bit) from T+1.
- Packet length: 96×(10+`GAP_BITS`)×`DIV` clocks from T+1. `done`=1 in the final cycle of that span.
- `busy` falls in the cycle after `done`. `tx`=1 throughout.
- All outputs are registered, so there are no combinational paths from inputs to outputs.

## Structure
- Shared package:
  - `JOB_BYTES`=96, `MIDSTATE_W`=512, `DATA2_W`=256.
  - FSM state enum.
  - A `baud_div(CLOCK,BAUD)` constant function, also used by the receiver side.
- One sub-module, `uart_tx_byte`:
  - Handles the baud counter, start/data/stop/gap framing and the byte-level valid/ready handshake.
  - `work_tx` keeps the shift register, byte counter and job-level `busy`/`done`.

## Test plan
- `CLOCK`=8, `BAUD`=1 (`DIV`=8), `GAP_BITS`=0; data2[7:0]=0xA5, `start` at cycle 10 → `tx`=0 for cycles 11–18, then bits 1,0,1,0,0,1,0,1 (8 cycles each), then stop=1 for 8 cycles.
- Same parameters; random job → 7680 clocks from `busy` rise to `done`. A bench UART decoder recovers 96 bytes equal to {midstate,data2} in the specified byte order.
- `GAP_BITS`=2 → each byte occupies 96 clocks. Total span = 9216 clocks; `tx`=1 during each gap.
- `start` pulsed at byte 40, and again coincident with `done` → output stream unchanged, exactly one `done`. `start` two cycles after `done` → second packet begins.
- `reset` asserted during byte 50, bit 3 → next cycle `tx`=1, `busy`=0, no `done`. A subsequent `start` sends the full 96 bytes from byte 0.
- Defaults (`DIV`=217) → first start bit lasts exactly 217 clocks, and the full packet takes 208320 clocks.
